// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM state encodings and flag bundle.
package alu_pkg;

   typedef enum logic [2:0] {
      OpAdd = 3'd0,
      OpSub = 3'd1,
      OpAnd = 3'd2,
      OpOr  = 3'd3,
      OpXor = 3'd4,
      OpShl = 3'd5,
      OpShr = 3'd6,
      OpMul = 3'd7
   } alu_op_t;

   typedef logic [1:0] alu_state_t;

   localparam alu_state_t StIdle = 2'd0;
   localparam alu_state_t StBusy = 2'd1;
   localparam alu_state_t StHold = 2'd2;

   typedef struct packed {
      logic z;
      logic c;
      logic v;
      logic s;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier; done_o pulses the cycle after the final partial product lands.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 2);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // The load folds in the first partial product so the final step lands in time for the
   // top level to register the product WIDTH clocks after acceptance.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (start_i) begin
         acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
         mcand_d  = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
         mplier_d = b_i >> 1;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CntW'(1);
         if (cnt_q == LastCnt) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign done_o    = done_q;
   assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, single-cycle ops and an iterative multiply.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             z_o,
   output logic             c_o,
   output logic             v_o,
   output logic             s_o
);

   localparam int unsigned Sh = $clog2(WIDTH);
   localparam int unsigned Msb = WIDTH - 1;

   alu_state_t         state_q, state_d;
   logic [WIDTH-1:0]   res_q, res_d;
   alu_flags_t         flags_q, flags_d;
   logic               out_valid_q, out_valid_d;

   alu_op_t            op;
   logic               accept;
   logic               mul_start, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [Sh-1:0]      sh;
   logic [WIDTH:0]     sum, diff, shl, shr;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c, alu_v;

   assign op         = alu_op_t'(op_i);
   assign in_ready_o = (state_q == StIdle) || ((state_q == StHold) && out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      sh   = b_i[Sh-1:0];
      sum  = {1'b0, a_i} + {1'b0, b_i};
      diff = {1'b0, a_i} - {1'b0, b_i};
      // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
      shl  = {1'b0, a_i} << sh;
      shr  = {a_i, 1'b0} >> sh;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OpAdd: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a_i[Msb] == b_i[Msb]) && (sum[Msb] != a_i[Msb]);
         end
         OpSub: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a_i[Msb] != b_i[Msb]) && (diff[Msb] != a_i[Msb]);
         end
         OpAnd: alu_res = a_i & b_i;
         OpOr:  alu_res = a_i | b_i;
         OpXor: alu_res = a_i ^ b_i;
         OpShl: begin
            alu_res = shl[WIDTH-1:0];
            alu_c   = shl[WIDTH];
         end
         OpShr: begin
            alu_res = shr[WIDTH:1];
            alu_c   = shr[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      flags_d   = flags_q;
      mul_start = 1'b0;
      case (state_q)
         StIdle, StHold: begin
            if (accept) begin
               if (op == OpMul) begin
                  mul_start = 1'b1;
                  state_d   = StBusy;
               end else begin
                  state_d = StHold;
                  res_d   = alu_res;
                  flags_d = '{z: ~|alu_res, c: alu_c, v: alu_v, s: alu_res[Msb]};
               end
            end else if ((state_q == StHold) && out_ready_i) begin
               state_d = StIdle;
            end
         end
         StBusy: begin
            if (mul_done) begin
               state_d = StHold;
               res_d   = mul_prod[WIDTH-1:0];
               flags_d = '{z: ~|mul_prod[WIDTH-1:0], c: |mul_prod[2*WIDTH-1:WIDTH], v: 1'b0,
                           s: mul_prod[Msb]};
            end
         end
         default: state_d = StIdle;
      endcase
      out_valid_d = (state_d == StHold);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         res_q       <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (a_i),
      .b_i       (b_i),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   assign out_valid_o = out_valid_q;
   assign result_o    = res_q;
   assign z_o         = flags_q.z;
   assign c_o         = flags_q.c;
   assign v_o         = flags_q.v;
   assign s_o         = flags_q.s;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=8 instance for most scenarios, WIDTH=4 for the short multiply.
module tb_alu_seq;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
   localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [2:0] op;
   logic [7:0] a, b, result;
   logic       z, c, v, s;
   logic [12:0] obs;  // {out_valid, result, z, c, v, s}

   logic       in_valid4, in_ready4, out_valid4;
   logic [2:0] op4;
   logic [3:0] a4, b4, result4;
   logic       z4, c4, v4, s4;
   logic [8:0] obs4;

   int n_cmp = 0;
   int n_err = 0;

   assign obs  = {out_valid, result, z, c, v, s};
   assign obs4 = {out_valid4, result4, z4, c4, v4, s4};

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
      .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
      .z_o(z), .c_o(c), .v_o(v), .s_o(s)
   );

   alu_seq #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid4), .in_ready_o(in_ready4), .op_i(op4),
      .a_i(a4), .b_i(b4), .out_valid_o(out_valid4), .out_ready_i(1'b1), .result_o(result4),
      .z_o(z4), .c_o(c4), .v_o(v4), .s_o(s4)
   );

   // Present one op for a single edge, then scramble the operands to prove they were sampled.
   task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~x; b = ~y; op = ~o;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      in_valid4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
      #12;
      n_cmp++; if (obs !== 13'h0) begin n_err++;
         $display("FAIL reset_outputs got %h want %h", obs, 13'h0); end
      @(posedge clk); #1; rst_n = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++;
         $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      issue(ADD, 8'h7F, 8'h01);
      n_cmp++; if (obs !== {1'b1, 8'h80, 4'b0011}) begin n_err++;
         $display("FAIL add_overflow got %h want %h", obs, {1'b1, 8'h80, 4'b0011}); end
      issue(ADD, 8'hFF, 8'h01);
      n_cmp++; if (obs !== {1'b1, 8'h00, 4'b1100}) begin n_err++;
         $display("FAIL add_carry got %h want %h", obs, {1'b1, 8'h00, 4'b1100}); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++;
         $display("FAIL add_drain got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; op = SUB; a = 8'h00; b = 8'h01;
      @(posedge clk); #1;
      n_cmp++; if (obs !== {1'b1, 8'hFF, 4'b0101}) begin n_err++;
         $display("FAIL sub_borrow got %h want %h", obs, {1'b1, 8'hFF, 4'b0101}); end
      op = SUB; a = 8'h80; b = 8'h01;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (obs !== {1'b1, 8'h7F, 4'b0010}) begin n_err++;
         $display("FAIL sub_overflow got %h want %h", obs, {1'b1, 8'h7F, 4'b0010}); end
   endtask

   task automatic test_logic();
      out_ready = 1'b1;
      issue(AND_, 8'hF0, 8'h3C);
      n_cmp++; if (obs !== {1'b1, 8'h30, 4'b0000}) begin n_err++;
         $display("FAIL and_op got %h want %h", obs, {1'b1, 8'h30, 4'b0000}); end
      issue(OR_, 8'h81, 8'h02);
      n_cmp++; if (obs !== {1'b1, 8'h83, 4'b0001}) begin n_err++;
         $display("FAIL or_op got %h want %h", obs, {1'b1, 8'h83, 4'b0001}); end
   endtask

   task automatic test_mul();
      out_ready = 1'b1;
      @(posedge clk); #1;
      issue(MUL, 8'h10, 8'h10);
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if ({out_valid, in_ready} !== 2'b00) begin n_err++;
            $display("FAIL mul_busy cycle %0d got valid/ready %b want 00", i,
                     {out_valid, in_ready}); end
         @(posedge clk); #1;
      end
      n_cmp++; if (obs !== {1'b1, 8'h00, 4'b1100}) begin n_err++;
         $display("FAIL mul_result got %h want %h", obs, {1'b1, 8'h00, 4'b1100}); end
      issue(MUL, 8'h0D, 8'h0B);
      for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
      n_cmp++; if (obs !== {1'b1, 8'h8F, 4'b0001}) begin n_err++;
         $display("FAIL mul_small got %h want %h", obs, {1'b1, 8'h8F, 4'b0001}); end
   endtask

   task automatic test_backpressure();
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(ADD, 8'h03, 8'h04);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({in_ready, obs} !== {1'b0, 1'b1, 8'h07, 4'b0000}) begin n_err++;
            $display("FAIL hold_stable cycle %0d got %h want %h", i, {in_ready, obs},
                     {1'b0, 1'b1, 8'h07, 4'b0000}); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1; in_valid = 1'b1; op = XOR_; a = 8'hF0; b = 8'hFF; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++;
         $display("FAIL drain_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (obs !== {1'b1, 8'h0F, 4'b0000}) begin n_err++;
         $display("FAIL drain_accept got %h want %h", obs, {1'b1, 8'h0F, 4'b0000}); end
   endtask

   task automatic test_shift();
      out_ready = 1'b1;
      issue(SHL, 8'h81, 8'h01);
      n_cmp++; if (obs !== {1'b1, 8'h02, 4'b0100}) begin n_err++;
         $display("FAIL shl_one got %h want %h", obs, {1'b1, 8'h02, 4'b0100}); end
      issue(SHL, 8'h81, 8'h08);
      n_cmp++; if (obs !== {1'b1, 8'h81, 4'b0001}) begin n_err++;
         $display("FAIL shl_zero got %h want %h", obs, {1'b1, 8'h81, 4'b0001}); end
      issue(SHR, 8'h01, 8'h01);
      n_cmp++; if (obs !== {1'b1, 8'h00, 4'b1100}) begin n_err++;
         $display("FAIL shr_one got %h want %h", obs, {1'b1, 8'h00, 4'b1100}); end
      issue(SHR, 8'hA0, 8'h05);
      n_cmp++; if (obs !== {1'b1, 8'h05, 4'b0000}) begin n_err++;
         $display("FAIL shr_five got %h want %h", obs, {1'b1, 8'h05, 4'b0000}); end
   endtask

   task automatic test_reset_mid_mul();
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(ADD, 8'h7F, 8'h01);
      out_ready = 1'b1;
      issue(MUL, 8'h03, 8'h05);
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      rst_n = 1'b0; #1;
      n_cmp++; if (obs !== 13'h0) begin n_err++;
         $display("FAIL async_reset got %h want %h", obs, 13'h0); end
      @(posedge clk); #1; rst_n = 1'b1; #1;
      n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++;
         $display("FAIL post_reset got %b want 10", {in_ready, out_valid}); end
      issue(ADD, 8'h02, 8'h03);
      n_cmp++; if (obs !== {1'b1, 8'h05, 4'b0000}) begin n_err++;
         $display("FAIL post_reset_add got %h want %h", obs, {1'b1, 8'h05, 4'b0000}); end
      for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
      n_cmp++; if (obs !== {1'b0, 8'h05, 4'b0000}) begin n_err++;
         $display("FAIL no_stale_mul got %h want %h", obs, {1'b0, 8'h05, 4'b0000}); end
   endtask

   task automatic test_width4_mul();
      in_valid4 = 1'b1; op4 = MUL; a4 = 4'hF; b4 = 4'hF;
      @(posedge clk); #1;
      in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if ({out_valid4, in_ready4} !== 2'b00) begin n_err++;
            $display("FAIL w4_busy cycle %0d got %b want 00", i, {out_valid4, in_ready4}); end
         @(posedge clk); #1;
      end
      n_cmp++; if (obs4 !== {1'b1, 4'h1, 4'b0100}) begin n_err++;
         $display("FAIL w4_mul got %h want %h", obs4, {1'b1, 4'h1, 4'b0100}); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_logic();
      test_mul();
      test_backpressure();
      test_shift();
      test_reset_mid_mul();
      test_width4_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
